// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NREQ level requesters.
// Grants a requester, holds tx_start for HOLD_TICKS baud ticks, waits FRAME_TICKS, then acks.
module uart_tx_arbiter #(
  parameter int          NREQ        = 4,
  parameter int          IDW         = 2,
  parameter logic [12:0] BAUD_DIV    = 13'h1457,
  parameter int          HOLD_TICKS  = 2,
  parameter int          FRAME_TICKS = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  output logic                busy,
  output logic [IDW-1:0]      grant_id,
  output logic [7:0]          tx_din,
  output logic                tx_start
);

  localparam int MAXT = (HOLD_TICKS > FRAME_TICKS) ? HOLD_TICKS : FRAME_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int SW   = IDW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [12:0]     baud_q, baud_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic            tx_start_q, tx_start_d;
  logic            tick_s;
  logic            found_s;
  logic [IDW-1:0]  win_s;
  logic [7:0]      data_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_s[g] = req_data[8*g +: 8];
  end

  // Free-running baud divider; the tick phase matches the UART's enable.
  always_comb begin
    baud_d = (baud_q == BAUD_DIV) ? 13'd0 : baud_q + 13'd1;
  end

  assign tick_s = (baud_q == 13'd1);

  // Round-robin scan starting just after the last winner.
  always_comb begin
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    logic           hit;
    found_s = 1'b0;
    win_s   = '0;
    sum     = '0;
    idx     = '0;
    hit     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum     = {1'b0, last_q} + SW'(k);
      idx     = (sum >= SW'(NREQ)) ? IDW'(sum - SW'(NREQ)) : IDW'(sum);
      hit     = req[idx] && !found_s;
      win_s   = hit ? idx : win_s;
      found_s = found_s | hit;
    end
  end

  // Frame sequencing: grant, hold start, time the frame, ack for one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    busy_d     = busy_q;
    tx_din_d   = tx_din_q;
    tx_start_d = tx_start_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_id_d = win_s;
          last_d     = win_s;
          tx_din_d   = data_s[win_s];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (tick_s && (cnt_q == CW'(HOLD_TICKS - 1))) begin
          tx_start_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_WAIT;
        end else if (tick_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WAIT: begin
        if (tick_s && (cnt_q == CW'(FRAME_TICKS - 1))) begin
          ack_d[grant_id_q] = 1'b1;
          state_d           = ST_DONE;
        end else if (tick_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= 13'd0;
      cnt_q      <= '0;
      last_q     <= IDW'(NREQ - 1);
      grant_id_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign tx_din   = tx_din_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner sequences,
// and randomized requesters checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BDIV  = 3;
  localparam int HOLD  = 2;
  localparam int FRAME = 14;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic [7:0]        tx_din;
  logic              tx_start;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .BAUD_DIV(13'd3), .HOLD_TICKS(HOLD), .FRAME_TICKS(FRAME)
  ) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .ack(ack),
    .busy(busy), .grant_id(grant_id), .tx_din(tx_din), .tx_start(tx_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phases tracked as remaining tick budgets.
  int          m_cnt, m_last, m_hold, m_frame, m_gid;
  bit          m_done, m_busy, m_start;
  logic [7:0]  m_din;
  logic [3:0]  m_ack;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_gid;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = NREQ - 1; m_hold = 0; m_frame = 0; m_gid = 0;
    m_done = 0; m_busy = 0; m_start = 0; m_din = 8'h00; m_ack = 4'h0;
  endtask

  task automatic step();
    logic [3:0]  r;
    logic [31:0] d;
    logic        rs;
    bit          tick;
    int          w;
    r = req; d = req_data; rs = n_rst;
    @(posedge clk);
    if (!rs) begin
      model_reset();
    end else begin
      tick  = (m_cnt == 1);
      m_cnt = (m_cnt == BDIV) ? 0 : m_cnt + 1;
      m_ack = 4'h0;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_frame > 0) begin
        if (tick) begin
          m_frame--;
          if (m_frame == 0) begin m_ack[m_gid] = 1'b1; m_done = 1; end
        end
      end else if (m_hold > 0) begin
        if (tick) begin
          m_hold--;
          if (m_hold == 0) begin m_start = 0; m_frame = FRAME; end
        end
      end else if (r != 4'h0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && r[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        m_gid = w; m_last = w; m_din = d[8*w +: 8];
        m_start = 1; m_busy = 1; m_hold = HOLD;
      end
    end
    #1;
    check("model", {16'h0, ack, busy, grant_id, tx_din, tx_start},
          {16'h0, m_ack, m_busy, 2'(m_gid), m_din, m_start});
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 200) begin step(); n++; end
    check(name, {31'h0, busy}, 32'h1);
  endtask

  task automatic run_entry(input int i);
    int hi, lo, n;
    bit stable;
    req = tbl[i].req; req_data = tbl[i].data;
    wait_busy("grant_seen");
    check("grant_id", {30'h0, grant_id}, tbl[i].exp_gid);
    check("tx_din", {24'h0, tx_din}, {24'h0, tbl[i].exp_din});
    req_data[8*tbl[i].exp_gid +: 8] = 8'hFF;
    hi = 1; lo = 0; n = 0; stable = 1;
    while (n < 200) begin
      step(); n++;
      if (tx_din !== tbl[i].exp_din) stable = 0;
      if (ack != 4'h0) break;
      if (tx_start) hi++; else lo++;
    end
    check("hold_len", {31'h0, (hi >= 5 && hi <= 8)}, 32'h1);
    check("frame_len", lo, 56);
    check("ack", {28'h0, ack}, 32'h1 << tbl[i].exp_gid);
    req[tbl[i].exp_gid] = 1'b0;
    step();
    if (tx_din !== tbl[i].exp_din) stable = 0;
    check("busy_drop", {27'h0, ack, busy}, 32'h0);
    check("din_stable", {31'h0, stable}, 32'h1);
  endtask

  initial begin
    tbl[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5};
    tbl[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
    tbl[2] = '{4'b1101, 32'h44332211, 2, 8'h33};
    tbl[3] = '{4'b1001, 32'h44332211, 3, 8'h44};
    tbl[4] = '{4'b1001, 32'h7700003C, 0, 8'h3C};
    tbl[5] = '{4'b1001, 32'h7700003C, 3, 8'h77};
    tbl[6] = '{4'b1001, 32'h7700003C, 0, 8'h3C};

    n_rst = 1'b0; req = 4'h0; req_data = 32'h0;
    model_reset();
    #1;
    check("reset_outputs", {16'h0, ack, busy, grant_id, tx_din, tx_start}, 32'h0);
    step(); step();
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) run_entry(i);

    // Early release: requester 2 drops after grant, requester 1 drops before any grant.
    begin
      int n; bit saw;
      req = 4'b0100; req_data = 32'h005A0000;
      wait_busy("early_grant");
      check("early_gid", {30'h0, grant_id}, 32'd2);
      req = 4'b0010;
      step(); step(); step();
      req = 4'b0000;
      n = 0;
      while (ack == 4'h0 && n < 200) begin step(); n++; end
      check("early_ack", {28'h0, ack}, 32'h4);
      saw = 0;
      for (int c = 0; c < 20; c++) begin step(); if (busy) saw = 1; end
      check("no_grant1", {31'h0, saw}, 32'h0);
    end

    // Reset in the middle of the frame wait.
    begin
      int n;
      req = 4'b0010; req_data = 32'h0000C700;
      wait_busy("rst_grant");
      n = 0;
      while (tx_start && n < 50) begin step(); n++; end
      for (int c = 0; c < 5; c++) step();
      n_rst = 1'b0;
      #1;
      check("rst_async", {16'h0, ack, busy, grant_id, tx_din, tx_start}, 32'h0);
      step();
      n_rst = 1'b1;
      req = 4'b0101; req_data = 32'h00110022;
      wait_busy("rst_regrant");
      check("rst_ptr_gid", {30'h0, grant_id}, 32'd0);
      check("rst_ptr_din", {24'h0, tx_din}, 32'h22);
    end

    // Randomized requesters obeying the hold-until-ack contract.
    for (int c = 0; c < 4000; c++) begin
      step();
      n_rst = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(7) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(31) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(3) == 0) req_data[8*i +: 8] = 8'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
